// File: rtl/stream_demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
// Optional broadcast support is enabled with the STREAM_DEMUX_BCAST_EN macro.
package stream_demux_pkg;

    // Occupancy of a per-channel one-entry output slot
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

    // Base bit index of channel k inside the flattened out_data bus
    function automatic int ch_slice(input int k, input int data_w = DEF_DATA_W);
        return k * data_w;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output slot for a single demux channel.
// Holds one beat; can be drained and refilled in the same cycle.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              can_accept
);

    slot_state_t       state_reg;
    logic [DATA_W-1:0] data_reg;

    // Slot FSM: load fills (or refills while draining), a drain without load empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SLOT_EMPTY;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                SLOT_EMPTY: begin
                    if (load) begin
                        state_reg <= SLOT_FULL;
                        data_reg  <= load_data;
                    end
                end
                SLOT_FULL: begin
                    // A load while FULL only happens when the consumer takes the old beat
                    if (load) begin
                        data_reg <= load_data;
                    end else if (out_ready) begin
                        state_reg <= SLOT_EMPTY;
                    end
                end
                default: state_reg <= SLOT_EMPTY;
            endcase
        end
    end

    assign out_valid  = (state_reg == SLOT_FULL);
    assign out_data   = data_reg;
    assign can_accept = ~out_valid | out_ready;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer with valid/ready handshake.
// Beats whose select is out of range are accepted, discarded and counted.
// Define STREAM_DEMUX_BCAST_EN to add the in_bcast port (load all channels at once).
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                     in_bcast,
`endif
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]         drop_cnt
);

    logic [NUM_CH-1:0] can_accept;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] load;
    logic              sel_legal;
    logic              sel_ready;
    logic              bcast_act;
    logic              accept;
    logic              drop_inc;
    logic [CNT_W-1:0]  drop_cnt_reg;

`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast_act = in_valid & in_bcast;
`else
    assign bcast_act = 1'b0;
`endif

    // Select decode; an out-of-range select hits no channel and is always ready
    always_comb begin
        sel_hit   = '0;
        sel_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_hit[k] = 1'b1;
                sel_ready  = can_accept[k];
            end
        end
    end

    assign sel_legal = |sel_hit;
    assign in_ready  = bcast_act ? (&can_accept) : sel_ready;
    assign accept    = in_valid & in_ready;
    assign drop_inc  = accept & ~bcast_act & ~sel_legal;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign load[gi] = accept & (bcast_act | sel_hit[gi]);

            stream_demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (load[gi]),
                .load_data  (in_data),
                .out_ready  (out_ready[gi]),
                .out_valid  (out_valid[gi]),
                .out_data   (out_data[ch_slice(gi, DATA_W) +: DATA_W]),
                .can_accept (can_accept[gi])
            );
        end
    endgenerate

    // Saturating count of beats dropped for an out-of-range select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (drop_inc && (drop_cnt_reg != {CNT_W{1'b1}})) begin
            drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: a 4-channel and a 3-channel instance
// share stimulus; a slot-occupancy reference model predicts every handshake.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst4_n, rst3_n;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_ready;
    logic        bcast;

    logic        ir4, ir3;
    logic [3:0]  ov4;
    logic [2:0]  ov3;
    logic [31:0] od4;
    logic [23:0] od3;
    logic [7:0]  dc4, dc3;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: which channel slots hold a beat, their payload, drop count
    int          cur;
    int          m_nch;
    bit          m_full [4];
    logic [7:0]  m_data [4];
    int          m_drop;

    always #5 clk = ~clk;

    stream_demux #(.DATA_W(8), .NUM_CH(4), .CNT_W(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst4_n),
        .in_valid  (in_valid),
        .in_ready  (ir4),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef STREAM_DEMUX_BCAST_EN
        .in_bcast  (bcast),
`endif
        .out_valid (ov4),
        .out_ready (out_ready),
        .out_data  (od4),
        .drop_cnt  (dc4)
    );

    stream_demux #(.DATA_W(8), .NUM_CH(3), .CNT_W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .in_valid  (in_valid),
        .in_ready  (ir3),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef STREAM_DEMUX_BCAST_EN
        .in_bcast  (bcast),
`endif
        .out_valid (ov3),
        .out_ready (out_ready[2:0]),
        .out_data  (od3),
        .drop_cnt  (dc3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int n);
        m_nch = n;
        m_drop = 0;
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 8'h00;
        end
    endtask

    function automatic bit model_ready(input bit v, input logic [1:0] s, input logic [3:0] r);
        bit all_ok;
        if (v && bcast) begin
            all_ok = 1'b1;
            for (int k = 0; k < m_nch; k++) all_ok &= (!m_full[k] || r[k]);
            return all_ok;
        end
        if (int'(s) < m_nch) return (!m_full[s] || r[s]);
        return 1'b1;
    endfunction

    // One transaction: drive at negedge, check handshake, advance model at posedge, check outputs
    task automatic step(input bit v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        bit          exp_ready;
        logic        ir;
        logic [3:0]  ov;
        logic [3:0]  ev;
        logic [31:0] od;
        logic [7:0]  dc;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_ready = model_ready(v, s, r);
        ir = (cur == 3) ? ir3 : ir4;
        check("in_ready", {31'd0, ir}, {31'd0, exp_ready});
        @(posedge clk);
        for (int k = 0; k < m_nch; k++) begin
            if (m_full[k] && r[k]) m_full[k] = 1'b0;
        end
        if (v && exp_ready) begin
            if (bcast) begin
                for (int k = 0; k < m_nch; k++) begin
                    m_full[k] = 1'b1;
                    m_data[k] = d;
                end
            end else if (int'(s) < m_nch) begin
                m_full[s] = 1'b1;
                m_data[s] = d;
            end else begin
                m_drop = (m_drop + 1 > 255) ? 255 : m_drop + 1;
            end
        end
        #1;
        ov = (cur == 3) ? {1'b0, ov3} : ov4;
        od = (cur == 3) ? {8'h00, od3} : od4;
        dc = (cur == 3) ? dc3 : dc4;
        for (int k = 0; k < 4; k++) ev[k] = m_full[k];
        check("out_valid", {28'd0, ov}, {28'd0, ev});
        check("drop_cnt", {24'd0, dc}, m_drop);
        for (int k = 0; k < m_nch; k++) begin
            if (m_full[k]) check($sformatf("out_data[%0d]", k), {24'd0, od[k*8 +: 8]}, {24'd0, m_data[k]});
        end
        $display("t=%0t dut%0d v=%0b sel=%0d data=%02h rdy=%04b ready=%0b valid=%04b drop=%0d",
                 $time, cur, v, s, d, r, ir, ov, dc);
    endtask

    initial begin
        // Reset held with in_valid asserted: nothing may load
        rst4_n = 1'b0;
        rst3_n = 1'b0;
        bcast = 1'b0;
        in_valid = 1'b1;
        in_sel = 2'd2;
        in_data = 8'hA5;
        out_ready = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid4", {28'd0, ov4}, 32'd0);
        check("reset drop_cnt4", {24'd0, dc4}, 32'd0);
        check("reset out_valid3", {29'd0, ov3}, 32'd0);
        check("reset drop_cnt3", {24'd0, dc3}, 32'd0);
        check("reset in_ready4", {31'd0, ir4}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst4_n = 1'b1;
        rst3_n = 1'b1;
        cur = 4;
        model_reset(4);

        // First beat after reset lands on channel 2 one cycle later
        step(1'b1, 2'd2, 8'hA5, 4'b0000);
        step(1'b0, 2'd0, 8'h00, 4'b1111);

        // Sweep of all channels at full throughput
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'h10 + 8'(i), 4'b1111);
        step(1'b0, 2'd0, 8'h00, 4'b1111);

        // Backpressure on channel 1, then drain-and-refill in one cycle
        step(1'b1, 2'd1, 8'h21, 4'b1101);
        step(1'b1, 2'd1, 8'h22, 4'b1101);
        step(1'b1, 2'd1, 8'h22, 4'b1111);

        // Channel 1 stalled while channel 3 keeps flowing
        step(1'b1, 2'd3, 8'h33, 4'b1101);
        step(1'b0, 2'd0, 8'h00, 4'b1111);

        // Random traffic on the 4-channel instance
        repeat (300) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
        end

`ifdef STREAM_DEMUX_BCAST_EN
        // Broadcast blocked by one full, stalled channel, then released
        step(1'b0, 2'd0, 8'h00, 4'b1111);
        step(1'b1, 2'd2, 8'h77, 4'b1011);
        bcast = 1'b1;
        step(1'b1, 2'd0, 8'h5A, 4'b1011);
        step(1'b1, 2'd0, 8'h5A, 4'b1111);
        bcast = 1'b0;
        step(1'b0, 2'd0, 8'h00, 4'b0000);
        repeat (100) begin
            bcast = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
        end
        bcast = 1'b0;
`endif

        // 3-channel instance: select 3 is illegal and drops saturate at 255
        @(negedge clk);
        in_valid = 1'b0;
        rst3_n = 1'b0;
        #1;
        rst3_n = 1'b1;
        cur = 3;
        model_reset(3);
        repeat (300) step(1'b1, 2'd3, 8'($urandom), 4'b1111);
        check("drop_cnt saturated", {24'd0, dc3}, 32'd255);
        repeat (100) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
        end

        // Asynchronous reset in the middle of a stream clears everything at once
        step(1'b1, 2'd0, 8'hC3, 4'b0000);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel = 2'd3;
        @(posedge clk);
        #3;
        rst3_n = 1'b0;
        #1;
        check("async rst drop_cnt", {24'd0, dc3}, 32'd0);
        check("async rst out_valid", {29'd0, ov3}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst3_n = 1'b1;
        model_reset(3);
        step(1'b1, 2'd1, 8'h3C, 4'b0000);
        step(1'b1, 2'd3, 8'h00, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
